// File: rtl/alu_writeback.sv
// ALU writeback stage: captures one ALU bundle, commits it to an 8-bit register file and SREG.
// Optional ALU_WB_BYPASS_EN forwards pending write data onto the read ports.
module alu_writeback #(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned ADDR_W   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_fsl,
    input  logic [ADDR_W-1:0] in_dest,
    input  logic [7:0]        in_result,
    input  logic [7:0]        in_mul_high,
    input  logic [3:0]        in_sreg,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [7:0]        rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [7:0]        rd_data_b,
    output logic [3:0]        sreg_q,
    output logic              busy,
    output logic              wb_done
);

    localparam logic [3:0] FslMul = 4'b1110;
    localparam logic [3:0] FslCmp = 4'b1111;

    typedef enum logic [1:0] {StIdle, StWriteLo, StWriteHi} state_e;

    state_e            state_q;
    logic [3:0]        fsl_q;
    logic [ADDR_W-1:0] dest_q;
    logic [7:0]        result_q;
    logic [7:0]        mul_high_q;
    logic [3:0]        sreg_held_q;
    logic [7:0]        regs_q [NUM_REGS];
    logic [ADDR_W-1:0] dest_hi;

    // NUM_REGS is a power of two, so the natural ADDR_W overflow gives the wrap to r0.
    assign dest_hi  = dest_q + ADDR_W'(1);
    assign in_ready = (state_q == StIdle);
    assign busy     = (state_q != StIdle);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            fsl_q       <= 4'h0;
            dest_q      <= '0;
            result_q    <= 8'h00;
            mul_high_q  <= 8'h00;
            sreg_held_q <= 4'h0;
            sreg_q      <= 4'h0;
            wb_done     <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            wb_done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        fsl_q       <= in_fsl;
                        dest_q      <= in_dest;
                        result_q    <= in_result;
                        mul_high_q  <= in_mul_high;
                        sreg_held_q <= in_sreg;
                        state_q     <= StWriteLo;
                    end
                end
                StWriteLo: begin
                    sreg_q <= sreg_held_q;
                    if (fsl_q != FslCmp) begin
                        regs_q[dest_q] <= result_q;
                    end
                    if (fsl_q == FslMul) begin
                        state_q <= StWriteHi;
                    end else begin
                        state_q <= StIdle;
                        wb_done <= 1'b1;
                    end
                end
                StWriteHi: begin
                    regs_q[dest_hi] <= mul_high_q;
                    state_q         <= StIdle;
                    wb_done         <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef ALU_WB_BYPASS_EN
    logic lo_pending;
    logic hi_pending;

    // COMPARE never writes the array, so it has nothing to forward.
    assign lo_pending = (state_q == StWriteLo) && (fsl_q != FslCmp);
    assign hi_pending = (state_q == StWriteHi);

    always_comb begin
        rd_data_a = regs_q[rd_addr_a];
        if (lo_pending && (rd_addr_a == dest_q)) begin
            rd_data_a = result_q;
        end else if (hi_pending && (rd_addr_a == dest_hi)) begin
            rd_data_a = mul_high_q;
        end
    end

    always_comb begin
        rd_data_b = regs_q[rd_addr_b];
        if (lo_pending && (rd_addr_b == dest_q)) begin
            rd_data_b = result_q;
        end else if (hi_pending && (rd_addr_b == dest_hi)) begin
            rd_data_b = mul_high_q;
        end
    end
`else
    assign rd_data_a = regs_q[rd_addr_a];
    assign rd_data_b = regs_q[rd_addr_b];
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Directed and randomized bench for alu_writeback against a transaction-level register-file model.
`timescale 1ns/100ps

module tb_alu_writeback;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_fsl;
  logic [2:0] in_dest;
  logic [7:0] in_result;
  logic [7:0] in_mul_high;
  logic [3:0] in_sreg;
  logic [2:0] rd_addr_a;
  logic [7:0] rd_data_a;
  logic [2:0] rd_addr_b;
  logic [7:0] rd_data_b;
  logic [3:0] sreg_q;
  logic       busy;
  logic       wb_done;

  int total = 0;
  int bad   = 0;

  // Architectural view of the stage: what the register file and SREG hold between transactions.
  logic [7:0] model_regs [8];
  logic [3:0] model_sreg;

  alu_writeback #(.NUM_REGS(8), .ADDR_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_fsl     (in_fsl),
    .in_dest    (in_dest),
    .in_result  (in_result),
    .in_mul_high(in_mul_high),
    .in_sreg    (in_sreg),
    .rd_addr_a  (rd_addr_a),
    .rd_data_a  (rd_data_a),
    .rd_addr_b  (rd_addr_b),
    .rd_data_b  (rd_data_b),
    .sreg_q     (sreg_q),
    .busy       (busy),
    .wb_done    (wb_done)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) model_regs[i] = 8'h00;
    model_sreg = 4'h0;
  endtask

  // Value a read port should show while a write to wr_addr of wr_val is pending.
  function automatic logic [7:0] pend_read(input logic [2:0] addr, input logic pending,
                                           input logic [2:0] wr_addr, input logic [7:0] wr_val);
`ifdef ALU_WB_BYPASS_EN
    if (pending && addr == wr_addr) return wr_val;
`endif
    return model_regs[addr];
  endfunction

  task automatic check_all(input string tag);
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 3'(i);
      rd_addr_b = 3'(7 - i);
      #1;
      chk(tag, rd_data_a, model_regs[i]);
      chk(tag, rd_data_b, model_regs[7 - i]);
    end
    chk(tag, sreg_q, model_sreg);
  endtask

  // One full transaction starting in IDLE, #1 after an edge; checks cycle-by-cycle behaviour.
  task automatic do_txn(input logic [3:0] fsl, input logic [2:0] dest, input logic [7:0] res,
                        input logic [7:0] mh, input logic [3:0] sr);
    logic [2:0] hi;
    logic       is_mul;
    logic       is_cmp;
    hi     = dest + 3'd1;
    is_mul = (fsl == 4'b1110);
    is_cmp = (fsl == 4'b1111);
    chk("txn_ready_before", in_ready, 1'b1);
    in_valid = 1'b1; in_fsl = fsl; in_dest = dest;
    in_result = res; in_mul_high = mh; in_sreg = sr;
    tick();
    // Garbage bundle held valid while busy must not be captured.
    in_fsl = 4'($urandom); in_dest = 3'($urandom); in_result = 8'($urandom);
    in_mul_high = 8'($urandom); in_sreg = 4'($urandom);
    chk("txn_busy_lo", busy, 1'b1);
    chk("txn_ready_lo", in_ready, 1'b0);
    rd_addr_a = dest;
    #1;
    chk("txn_read_lo", rd_data_a, pend_read(dest, !is_cmp, dest, res));
    in_valid = 1'b0;
    tick();
    if (!is_cmp) model_regs[dest] = res;
    model_sreg = sr;
    if (is_mul) begin
      chk("txn_busy_hi", busy, 1'b1);
      chk("txn_done_hi", wb_done, 1'b0);
      chk("txn_sreg_hi", sreg_q, model_sreg);
      rd_addr_a = dest;
      rd_addr_b = hi;
      #1;
      chk("txn_lo_committed", rd_data_a, model_regs[dest]);
      chk("txn_read_hi", rd_data_b, pend_read(hi, 1'b1, hi, mh));
      tick();
      model_regs[hi] = mh;
    end
    chk("txn_done", wb_done, 1'b1);
    chk("txn_ready_after", in_ready, 1'b1);
    check_all("txn_regs");
    tick();
    chk("txn_done_clear", wb_done, 1'b0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_fsl = 4'h0; in_dest = 3'd0;
    in_result = 8'h00; in_mul_high = 8'h00; in_sreg = 4'h0;
    rd_addr_a = 3'd0; rd_addr_b = 3'd0;
    model_reset();
    tick();
    tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", wb_done, 1'b0);
    check_all("rst_regs");
    reset = 1'b0;
    tick();
    chk("rst_ready", in_ready, 1'b1);

    // Reset during WRITE_LO discards the pending ADD.
    in_valid = 1'b1; in_fsl = 4'b0000; in_dest = 3'd2; in_result = 8'h5A; in_sreg = 4'b1010;
    tick();
    in_valid = 1'b0;
    chk("midrst_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("midrst_async", busy, 1'b0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst_no_done", wb_done, 1'b0);
    end
    chk("midrst_ready", in_ready, 1'b1);
    check_all("midrst_regs");

    do_txn(4'b0000, 3'd3, 8'h7F, 8'h00, 4'b0100);
    do_txn(4'b1110, 3'd7, 8'h10, 8'hE1, 4'b0010);
    do_txn(4'b0000, 3'd4, 8'h33, 8'h00, 4'b0000);
    do_txn(4'b1111, 3'd4, 8'h99, 8'h00, 4'b0001);
    do_txn(4'b0000, 3'd5, 8'h24, 8'h00, 4'b1000);
    do_txn(4'b0001, 3'd5, 8'hC3, 8'h00, 4'b0011);

    // Back-to-back: in_valid held high, bundle B presented while A is in flight.
    in_valid = 1'b1; in_fsl = 4'b0000; in_dest = 3'd1; in_result = 8'h11; in_sreg = 4'b0101;
    tick();
    in_dest = 3'd6; in_result = 8'h66; in_sreg = 4'b1001;
    chk("b2b_ready_a", in_ready, 1'b0);
    tick();
    model_regs[1] = 8'h11; model_sreg = 4'b0101;
    chk("b2b_ready_b", in_ready, 1'b1);
    chk("b2b_done_a", wb_done, 1'b1);
    check_all("b2b_a_regs");
    tick();
    in_valid = 1'b0;
    chk("b2b_busy_b", busy, 1'b1);
    tick();
    model_regs[6] = 8'h66; model_sreg = 4'b1001;
    chk("b2b_done_b", wb_done, 1'b1);
    check_all("b2b_b_regs");
    tick();

    for (int n = 0; n < 40; n++) begin
      do_txn(4'($urandom), 3'($urandom), 8'($urandom), 8'($urandom), 4'($urandom));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
